// File: rtl/ram_stream_reader_pkg.sv
// ram_stream_reader_pkg: FSM states, output FIFO depth and address-width helper
package ram_stream_reader_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam int FDEPTH = 4;
    function automatic int log2_min1(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/ram_stream_reader_fifo.sv
// stream_fifo_small: first-word fall-through FIFO with occupancy count
module stream_fifo_small
    import ram_stream_reader_pkg::*;
#(
    parameter int W = 33
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(FDEPTH):0]  count,
    output logic                     empty
);
    localparam int PW = $clog2(FDEPTH);
    logic [W-1:0]  mem [FDEPTH];
    logic [PW-1:0] wp, rp;
    logic          do_push, do_pop;
    assign empty   = count == '0;
    assign do_pop  = pop & !empty;
    assign do_push = push & (count != (PW+1)'(FDEPTH) | do_pop);
    assign dout    = mem[rp];
    always_ff @(posedge clk)
        if (do_push) mem[wp] <= din;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: sequential RAM reads presented as a valid/ready stream
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int BYTES  = 4,
    parameter int DEPTH  = 256,
    parameter int AWIDTH = log2_min1(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AWIDTH-1:0]    base_addr,
    input  logic [AWIDTH:0]      length,
    output logic                 busy,
    output logic                 done,
    output logic [AWIDTH-1:0]    ram_address,
    output logic                 ram_ce,
    output logic                 ram_we,
    output logic [BYTES-1:0]     ram_be,
    input  logic [BYTES*8-1:0]   ram_q,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [BYTES*8-1:0]   m_data,
    output logic                 m_last
);
    localparam int DW = BYTES*8;
    localparam int CW = $clog2(FDEPTH) + 2;
    localparam logic [AWIDTH:0] ONE = 1;
    state_t                  state, state_n;
    logic [AWIDTH-1:0]       addr, cur;
    logic [AWIDTH:0]         rem;
    logic                    q_valid, q_last, ce_last, issue, last_issue, launch, empty;
    logic [$clog2(FDEPTH):0] count;
    logic [CW-1:0]           occ;
    logic [DW:0]             dout;

    function automatic logic [AWIDTH-1:0] next_addr(input logic [AWIDTH-1:0] a);
        return a == AWIDTH'(DEPTH-1) ? '0 : a + 1'b1;
    endfunction

    // occupancy counts buffered words plus reads in the ce and q cycles
    assign occ = CW'(count) + CW'(ram_ce) + CW'(q_valid);

    always_comb begin
        launch     = state == IDLE && start && length != '0;
        issue      = launch || (state == RUN && rem != '0 && occ < CW'(FDEPTH));
        last_issue = launch ? length == ONE : rem == ONE;
        cur        = launch ? base_addr : addr;
        state_n    = state;
        case (state)
            IDLE:    state_n = start ? (length != '0 ? RUN : DONE) : IDLE;
            RUN:     state_n = (issue && last_issue) || rem == '0 ? DRAIN : RUN;
            DRAIN:   state_n = m_valid && m_ready && m_last ? DONE : DRAIN;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state       <= IDLE;
            addr        <= '0;
            rem         <= '0;
            ram_ce      <= 1'b0;
            ram_address <= '0;
            ce_last     <= 1'b0;
            q_valid     <= 1'b0;
            q_last      <= 1'b0;
        end else begin
            state   <= state_n;
            ram_ce  <= issue;
            ce_last <= issue & last_issue;
            q_valid <= ram_ce;
            q_last  <= ce_last;
            if (issue) begin
                ram_address <= cur;
                addr        <= next_addr(cur);
                rem         <= (launch ? length : rem) - ONE;
            end
        end

    stream_fifo_small #(.W(DW + 1)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (q_valid),
        .pop   (m_valid & m_ready),
        .din   ({q_last, ram_q}),
        .dout  (dout),
        .count (count),
        .empty (empty)
    );

    assign busy    = state != IDLE;
    assign done    = state == DONE;
    assign ram_we  = 1'b0;
    assign ram_be  = '0;
    assign m_valid = !empty;
    assign m_data  = dout[DW-1:0];
    assign m_last  = m_valid & dout[DW];
endmodule
